map_ram_arbiter: RTL and testbench
==================================

Name: map_ram_arbiter

Overview:
- Arbitrates the single-port 16x32 map RAM between three requesters: draw (read-only, highest priority) and player1/player2 rope logic (read/write).
- Issues at most one RAM access per cycle and returns read data tagged to its requester after a fixed RAM latency.
- Provides a lock so a player can do an atomic read-modify-write of a map cell (e.g. removing caught gold).
- Sits between the drawing engine, the two rope controllers, and the map RAM macro.

Parameters:
ADDR_W, 4, map RAM address width
DATA_W, 32, map cell width
RD_LAT, 1, RAM read latency in cycles (1..3)
STARVE_MAX, 8, maximum consecutive draw grants allowed while a player request is pending
HOLD_MAX, 15, maximum cycles a player lock may be held before forced release

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
enable  in  1  0 = issue no new accesses; in-flight reads still return
draw_req  in  1  draw read request, one access per cycle
draw_addr  in  ADDR_W  draw read address
draw_rvalid  out  1  pulse: rdata belongs to draw
p_req  in  2  per-player request, level, held until p_done
p_we  in  2  per-player write enable (1 = write)
p_lock  in  2  per-player lock hold after the current access
p_addr  in  2*ADDR_W  player addresses, {p2,p1}
p_wdata  in  2*DATA_W  player write data, {p2,p1}
p_done  out  2  one-cycle completion pulse per player
lock_timeout  out  1  pulse when a lock is force-released
rdata  out  DATA_W  registered read data
ram_addr  out  ADDR_W  RAM address, registered
ram_wdata  out  DATA_W  RAM write data, registered
ram_wren  out  1  RAM write strobe, registered
ram_q  in  DATA_W  RAM read data

Behaviour:
- Reset: all outputs 0, FSM in S_IDLE, tag pipe cleared, RR pointer = player1, counters 0.
- Reset mid-access aborts the access: ram_wren is 0 after the edge and no done or valid pulse is issued.
- Tag pipe: RD_LAT-deep shift of 2-bit tags: NONE, DRAW, P1, P2. A tag is pushed on every read issue.
- When a tag exits the pipe, ram_q is captured into rdata. A DRAW tag pulses draw_rvalid; a P1 or P2 tag pulses the matching p_done in the same cycle.
- Issue priority per cycle, when enable = 1 and the FSM is in S_IDLE or S_HOLD:
  - Draw wins, unless starve_cnt == STARVE_MAX and a player is eligible, in which case the player wins.
  - starve_cnt increments on each draw issue while a player request is pending. It clears on any player issue or when no player request is pending.
- Player eligibility:
  - In S_IDLE, both players are eligible.
  - In S_HOLD, only the lock owner is eligible.
  - If both are eligible, round-robin: the player not granted last wins, and the pointer updates on grant.
- Write: registers ram_addr, ram_wdata and ram_wren = 1 for exactly 1 cycle. p_done pulses the following cycle.
- Read: issues ram_addr and pushes the tag. The FSM enters S_WAIT until that player's tag exits. Draw reads continue to issue during S_WAIT; the other player is blocked.
- A player with a request in flight is not re-granted until its p_done.
- If p_req is still high in the cycle after p_done, it is a new request.
- FSM states: S_IDLE, S_WRITE, S_WAIT, S_HOLD.
  - S_WRITE and S_WAIT return to S_HOLD if p_lock[owner] = 1 at completion, else to S_IDLE.
  - S_HOLD exits to S_IDLE when p_lock[owner] = 0.
  - S_HOLD also exits when hold_cnt reaches HOLD_MAX, which pulses lock_timeout. hold_cnt counts cycles in S_HOLD with no access issued.
- enable = 0: no new issues. Pipe drains, the FSM completes its current access, and counters hold.
- Draw and player writes to the same address in one cycle: draw reads first; the player write issues no earlier than the next cycle.

Optional Feature:
- MAP_ARB_STATS_EN defined: adds output stat_conflicts[15:0]. It counts cycles with at least 2 pending requesters (draw_req counts), saturates at 16'hFFFF, and clears on reset.
- Undefined: the port exists and is tied to 0, and no counter logic is built.

Decomposition:
- Package map_arb_pkg holds the FSM state encoding, the tag codes (NONE/DRAW/P1/P2), and the requester index constants.
- One sub-module, map_rd_tag_pipe (RD_LAT-parameterised tag shift register with exit decode), instantiated once.

Test Plan:
- draw_req held 4 cycles at addresses 0..3 with RAM preloaded 0xA0+i, RD_LAT = 1 -> draw_rvalid on cycles 2..5 with rdata 0xA0..0xA3.
- Both players write simultaneously (p1 addr 5 = 0x11, p2 addr 6 = 0x22) -> p1 issued first, then p2; each ram_wren is a single cycle; p_done = 01 then 10; readback is correct.
- draw_req held continuously with p1 read pending, STARVE_MAX = 8 -> p1 issued after exactly 8 draw issues, then draw resumes.
- p1 locks, reads addr 3, then writes addr 3 while p2 requests throughout -> p2 is not issued until p_lock[0] drops.
- p1 lock held with no accesses -> S_HOLD exits after 15 cycles with one lock_timeout pulse, then p2 is granted.
- resetn asserted during an S_WAIT player read -> no p_done; all outputs 0 next cycle; tag pipe empty.

Source files
------------

// File: rtl/map_arb_pkg.sv
// rtl/map_arb_pkg.sv - shared types and constants for the map RAM arbiter
//
// Purpose: FSM state encoding, read-tag codes and requester indices used by
//          map_ram_arbiter and map_rd_tag_pipe.
// Ports:   none (package)
package map_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DRAW = 2'd1,
      TAG_P1   = 2'd2,
      TAG_P2   = 2'd3
   } tag_t;

   localparam int REQ_P1   = 0;
   localparam int REQ_P2   = 1;
   localparam int REQ_DRAW = 2;

endpackage

// File: rtl/map_rd_tag_pipe.sv
// rtl/map_rd_tag_pipe.sv - read-latency tag shift register with exit decode
//
// Purpose: follows each read issue through the RAM latency so the returning
//          ram_q word can be attributed to its requester.
// Ports:   clock, resetn   - clock, synchronous active-low reset
//          i_tag           - tag pushed this cycle (TAG_NONE when no read)
//          o_exit_draw/p1/p2 - tag leaving the pipe this cycle
//          o_exit_any      - any non-empty tag leaving the pipe
module map_rd_tag_pipe
   import map_arb_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic clock,
   input  logic resetn,
   input  tag_t i_tag,
   output logic o_exit_draw,
   output logic o_exit_p1,
   output logic o_exit_p2,
   output logic o_exit_any
);

   tag_t r_pipe [RD_LAT];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= TAG_NONE;
      end else begin
         r_pipe[0] <= i_tag;
         for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_exit_draw = (r_pipe[RD_LAT-1] == TAG_DRAW);
   assign o_exit_p1   = (r_pipe[RD_LAT-1] == TAG_P1);
   assign o_exit_p2   = (r_pipe[RD_LAT-1] == TAG_P2);
   assign o_exit_any  = (r_pipe[RD_LAT-1] != TAG_NONE);

endmodule

// File: rtl/map_ram_arbiter.sv
// rtl/map_ram_arbiter.sv - single-port map RAM arbiter for draw and two players
//
// Purpose: one RAM access per cycle; draw reads have priority with starvation
//          relief for players; players may lock the RAM for read-modify-write.
// Option:  MAP_ARB_STATS_EN builds the o_stat_conflicts counter (else tied 0).
// Ports:   clock, resetn        - clock, synchronous active-low reset
//          i_enable             - 0 stops new issues, in-flight reads drain
//          i_draw_req/addr      - draw read request, o_draw_rvalid on return
//          i_p_req/we/lock/addr/wdata - player requests {p2,p1}
//          o_p_done             - per-player completion pulse
//          o_lock_timeout       - pulse on forced lock release
//          o_rdata              - registered read data
//          o_ram_addr/wdata/wren, i_ram_q - RAM macro interface
//          o_stat_conflicts     - cycles with 2+ requesters (saturating)
module map_ram_arbiter
   import map_arb_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 8,
   parameter int HOLD_MAX   = 15
)(
   input  logic                clock,
   input  logic                resetn,
   input  logic                i_enable,
   input  logic                i_draw_req,
   input  logic [ADDR_W-1:0]   i_draw_addr,
   output logic                o_draw_rvalid,
   input  logic [1:0]          i_p_req,
   input  logic [1:0]          i_p_we,
   input  logic [1:0]          i_p_lock,
   input  logic [2*ADDR_W-1:0] i_p_addr,
   input  logic [2*DATA_W-1:0] i_p_wdata,
   output logic [1:0]          o_p_done,
   output logic                o_lock_timeout,
   output logic [DATA_W-1:0]   o_rdata,
   output logic [ADDR_W-1:0]   o_ram_addr,
   output logic [DATA_W-1:0]   o_ram_wdata,
   output logic                o_ram_wren,
   input  logic [DATA_W-1:0]   i_ram_q,
   output logic [15:0]         o_stat_conflicts
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int HW = $clog2(HOLD_MAX + 1);

   state_t          r_state;
   logic            r_owner;      // player of the current/locked access
   logic            r_rr;         // player preferred on the next tie
   logic [SW-1:0]   r_starve;
   logic [HW-1:0]   r_hold;

   logic            w_in_arb, w_draw_ok, w_pick, w_p_go, w_d_go, w_pick_we;
   logic [1:0]      w_elig;
   logic [ADDR_W-1:0] w_pick_addr;
   logic [DATA_W-1:0] w_pick_wdata;
   tag_t            w_push_tag;
   logic            w_exit_draw, w_exit_p1, w_exit_p2, w_exit_any, w_owner_exit;
   state_t          w_done_state;

   assign w_in_arb  = (r_state == S_IDLE) || (r_state == S_HOLD);
   assign w_draw_ok = i_enable && i_draw_req && (w_in_arb || r_state == S_WAIT);

   // The done-pulse cycle is masked so a still-high p_req only counts as a
   // new request from the following cycle on.
   assign w_elig[REQ_P1] = i_enable && i_p_req[REQ_P1] && !o_p_done[REQ_P1] &&
                           ((r_state == S_IDLE) || (r_state == S_HOLD && !r_owner));
   assign w_elig[REQ_P2] = i_enable && i_p_req[REQ_P2] && !o_p_done[REQ_P2] &&
                           ((r_state == S_IDLE) || (r_state == S_HOLD && r_owner));

   assign w_pick       = (&w_elig) ? r_rr : w_elig[REQ_P2];
   assign w_p_go       = (|w_elig) && (!w_draw_ok || r_starve == SW'(STARVE_MAX));
   assign w_d_go       = w_draw_ok && !w_p_go;
   assign w_pick_we    = w_pick ? i_p_we[REQ_P2] : i_p_we[REQ_P1];
   assign w_pick_addr  = w_pick ? i_p_addr[2*ADDR_W-1:ADDR_W] : i_p_addr[ADDR_W-1:0];
   assign w_pick_wdata = w_pick ? i_p_wdata[2*DATA_W-1:DATA_W] : i_p_wdata[DATA_W-1:0];
   assign w_owner_exit = r_owner ? w_exit_p2 : w_exit_p1;
   assign w_done_state = i_p_lock[r_owner] ? S_HOLD : S_IDLE;

   always_comb begin
      w_push_tag = TAG_NONE;
      if (w_d_go)                      w_push_tag = TAG_DRAW;
      else if (w_p_go && !w_pick_we)   w_push_tag = w_pick ? TAG_P2 : TAG_P1;
   end

   map_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clock       (clock),
      .resetn      (resetn),
      .i_tag       (w_push_tag),
      .o_exit_draw (w_exit_draw),
      .o_exit_p1   (w_exit_p1),
      .o_exit_p2   (w_exit_p2),
      .o_exit_any  (w_exit_any)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state        <= S_IDLE;
         r_owner        <= 1'b0;
         r_rr           <= 1'b0;
         r_starve       <= '0;
         r_hold         <= '0;
         o_draw_rvalid  <= 1'b0;
         o_p_done       <= '0;
         o_lock_timeout <= 1'b0;
         o_rdata        <= '0;
         o_ram_addr     <= '0;
         o_ram_wdata    <= '0;
         o_ram_wren     <= 1'b0;
      end else begin
         o_draw_rvalid  <= w_exit_draw;
         o_p_done       <= {w_exit_p2, w_exit_p1};
         o_lock_timeout <= 1'b0;
         o_ram_wren     <= 1'b0;
         if (w_exit_any) o_rdata <= i_ram_q;

         if (w_d_go) begin
            o_ram_addr <= i_draw_addr;
         end else if (w_p_go) begin
            o_ram_addr <= w_pick_addr;
            r_owner    <= w_pick;
            r_rr       <= ~w_pick;
            if (w_pick_we) begin
               o_ram_wdata <= w_pick_wdata;
               o_ram_wren  <= 1'b1;
               r_state     <= S_WRITE;
            end else begin
               r_state     <= S_WAIT;
            end
         end

         // Starvation counter only sees draw wins over an eligible player.
         if (i_enable) begin
            if (w_p_go || !(|w_elig)) r_starve <= '0;
            else if (w_d_go)          r_starve <= r_starve + 1'b1;
         end

         case (r_state)
            S_WRITE: begin
               o_p_done[r_owner] <= 1'b1;
               r_state           <= w_done_state;
               r_hold            <= '0;
            end
            S_WAIT: begin
               if (w_owner_exit) begin
                  r_state <= w_done_state;
                  r_hold  <= '0;
               end
            end
            S_HOLD: begin
               if (!w_p_go) begin
                  if (!i_p_lock[r_owner]) begin
                     r_state <= S_IDLE;
                  end else if (i_enable && !w_d_go) begin
                     if (r_hold == HW'(HOLD_MAX - 1)) begin
                        r_state        <= S_IDLE;
                        r_hold         <= '0;
                        o_lock_timeout <= 1'b1;
                     end else begin
                        r_hold <= r_hold + 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MAP_ARB_STATS_EN
   logic [15:0] r_conflicts;
   logic [1:0]  w_nreq;

   assign w_nreq = {1'b0, i_draw_req} + {1'b0, i_p_req[REQ_P1]} + {1'b0, i_p_req[REQ_P2]};

   always_ff @(posedge clock) begin
      if (!resetn)                                     r_conflicts <= '0;
      else if (w_nreq >= 2'd2 && r_conflicts != 16'hFFFF) r_conflicts <= r_conflicts + 16'd1;
   end

   assign o_stat_conflicts = r_conflicts;
`else
   assign o_stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb/tb_map_ram_arbiter.sv - directed self-checking bench for map_ram_arbiter
module tb_map_ram_arbiter;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        enable, draw_req, draw_rvalid, lock_timeout, ram_wren;
   logic [3:0]  draw_addr, ram_addr;
   logic [1:0]  p_req, p_we, p_lock, p_done;
   logic [7:0]  p_addr;
   logic [63:0] p_wdata;
   logic [31:0] rdata, ram_wdata, ram_q;
   logic [15:0] stat_conflicts;

   logic [31:0] mem [16];
   logic        pl_we = 1'b0;
   logic [3:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // RAM model: read data follows the registered address (total latency 1)
   assign ram_q = mem[ram_addr];
   always @(posedge clock) begin
      if (ram_wren)   mem[ram_addr] <= ram_wdata;
      else if (pl_we) mem[pl_addr]  <= pl_data;
   end

   map_ram_arbiter #(
      .ADDR_W(4), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(8), .HOLD_MAX(15)
   ) dut (
      .clock            (clock),
      .resetn           (resetn),
      .i_enable         (enable),
      .i_draw_req       (draw_req),
      .i_draw_addr      (draw_addr),
      .o_draw_rvalid    (draw_rvalid),
      .i_p_req          (p_req),
      .i_p_we           (p_we),
      .i_p_lock         (p_lock),
      .i_p_addr         (p_addr),
      .i_p_wdata        (p_wdata),
      .o_p_done         (p_done),
      .o_lock_timeout   (lock_timeout),
      .o_rdata          (rdata),
      .o_ram_addr       (ram_addr),
      .o_ram_wdata      (ram_wdata),
      .o_ram_wren       (ram_wren),
      .i_ram_q          (ram_q),
      .o_stat_conflicts (stat_conflicts)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      enable = 1'b1; draw_req = 1'b0; draw_addr = '0;
      p_req = '0; p_we = '0; p_lock = '0; p_addr = '0; p_wdata = '0;
   endtask

   // Holds reset while preloading mem[i] = 0xA0 + i
   task automatic do_reset();
      resetn = 1'b0;
      idle_inputs();
      pl_we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pl_addr = 4'(i);
         pl_data = 32'(32'hA0 + i);
         tick();
      end
      pl_we  = 1'b0;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (draw_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", draw_rvalid); end
      checks++; if (p_done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", p_done); end
      checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", lock_timeout); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if (ram_addr !== 4'h0) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
      checks++; if (ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_ram_wdata: got %h expected 0", ram_wdata); end
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren: got %b expected 0", ram_wren); end
      checks++; if (stat_conflicts !== 16'h0) begin errors++; $display("FAIL reset_stat: got %h expected 0", stat_conflicts); end
   endtask

   task automatic test_draw_stream();
      logic exp_rv;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         draw_req  = (k <= 4);
         draw_addr = 4'(k - 1);
         tick();
         exp_rv = (k >= 2 && k <= 5);
         checks++; if (draw_rvalid !== exp_rv) begin errors++; $display("FAIL draw_rvalid k=%0d: got %b expected %b", k, draw_rvalid, exp_rv); end
         if (k >= 2 && k <= 5) begin
            checks++; if (rdata !== 32'(32'hA0 + k - 2)) begin errors++; $display("FAIL draw_rdata k=%0d: got %h expected %h", k, rdata, 32'(32'hA0 + k - 2)); end
         end
         if (k <= 4) begin
            checks++; if (ram_addr !== 4'(k - 1)) begin errors++; $display("FAIL draw_ram_addr k=%0d: got %h expected %h", k, ram_addr, 4'(k - 1)); end
         end
      end
   endtask

   task automatic test_two_writes();
      do_reset();
      p_req = 2'b11; p_we = 2'b11; p_addr = {4'd6, 4'd5}; p_wdata = {32'h22, 32'h11};
      tick();
      checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 4'd5, 32'h11}) begin errors++; $display("FAIL wr_p1_issue: got %b/%h/%h expected 1/5/11", ram_wren, ram_addr, ram_wdata); end
      checks++; if (p_done !== 2'b00) begin errors++; $display("FAIL wr_p1_early_done: got %b expected 00", p_done); end
      tick();
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wr_p1_single: got %b expected 0", ram_wren); end
      checks++; if (p_done !== 2'b01) begin errors++; $display("FAIL wr_p1_done: got %b expected 01", p_done); end
      p_req = 2'b10;
      tick();
      checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 4'd6, 32'h22}) begin errors++; $display("FAIL wr_p2_issue: got %b/%h/%h expected 1/6/22", ram_wren, ram_addr, ram_wdata); end
      tick();
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wr_p2_single: got %b expected 0", ram_wren); end
      checks++; if (p_done !== 2'b10) begin errors++; $display("FAIL wr_p2_done: got %b expected 10", p_done); end
      p_req = 2'b00; p_we = 2'b00;
      draw_req = 1'b1; draw_addr = 4'd5;
      tick();
      draw_addr = 4'd6;
      tick();
      checks++; if ({draw_rvalid, rdata} !== {1'b1, 32'h11}) begin errors++; $display("FAIL wr_readback5: got %b/%h expected 1/11", draw_rvalid, rdata); end
      draw_req = 1'b0;
      tick();
      checks++; if ({draw_rvalid, rdata} !== {1'b1, 32'h22}) begin errors++; $display("FAIL wr_readback6: got %b/%h expected 1/22", draw_rvalid, rdata); end
   endtask

   task automatic test_starve();
      logic [3:0] exp_addr;
      logic       exp_rv;
      logic [1:0] exp_done;
      do_reset();
      draw_req = 1'b1; draw_addr = 4'd0;
      p_req = 2'b01; p_we = 2'b00; p_addr = 8'h09;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_addr = (k == 9) ? 4'd9 : 4'd0;
         exp_rv   = (k >= 2 && k != 10);
         exp_done = (k == 10) ? 2'b01 : 2'b00;
         checks++; if (ram_addr !== exp_addr) begin errors++; $display("FAIL starve_addr k=%0d: got %h expected %h", k, ram_addr, exp_addr); end
         checks++; if (draw_rvalid !== exp_rv) begin errors++; $display("FAIL starve_rvalid k=%0d: got %b expected %b", k, draw_rvalid, exp_rv); end
         checks++; if (p_done !== exp_done) begin errors++; $display("FAIL starve_done k=%0d: got %b expected %b", k, p_done, exp_done); end
         if (k == 10) begin
            checks++; if (rdata !== 32'hA9) begin errors++; $display("FAIL starve_p1_rdata: got %h expected a9", rdata); end
            p_req = 2'b00;
         end
      end
      draw_req = 1'b0;
   endtask

   task automatic test_lock();
      do_reset();
      p_req = 2'b11; p_we = 2'b10; p_lock = 2'b01;
      p_addr = {4'd7, 4'd3}; p_wdata = {32'h77, 32'h0};
      tick();
      checks++; if ({ram_wren, ram_addr} !== {1'b0, 4'd3}) begin errors++; $display("FAIL lock_read_issue: got %b/%h expected 0/3", ram_wren, ram_addr); end
      tick();
      checks++; if ({p_done, rdata} !== {2'b01, 32'hA3}) begin errors++; $display("FAIL lock_read_done: got %b/%h expected 01/a3", p_done, rdata); end
      p_we = 2'b11; p_wdata = {32'h77, 32'hA4};
      tick();
      checks++; if ({ram_wren, p_done} !== 3'b000) begin errors++; $display("FAIL lock_hold_gap: got %b/%b expected 0/00", ram_wren, p_done); end
      tick();
      checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 4'd3, 32'hA4}) begin errors++; $display("FAIL lock_write_issue: got %b/%h/%h expected 1/3/a4", ram_wren, ram_addr, ram_wdata); end
      tick();
      checks++; if (p_done !== 2'b01) begin errors++; $display("FAIL lock_write_done: got %b expected 01", p_done); end
      p_req = 2'b10;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if ({ram_wren, p_done[1]} !== 2'b00) begin errors++; $display("FAIL lock_p2_blocked k=%0d: got %b/%b expected 0/0", k, ram_wren, p_done[1]); end
      end
      p_lock = 2'b00;
      tick();
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL lock_release_gap: got %b expected 0", ram_wren); end
      tick();
      checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 4'd7, 32'h77}) begin errors++; $display("FAIL lock_p2_issue: got %b/%h/%h expected 1/7/77", ram_wren, ram_addr, ram_wdata); end
      tick();
      checks++; if (p_done !== 2'b10) begin errors++; $display("FAIL lock_p2_done: got %b expected 10", p_done); end
      p_req = 2'b00; p_we = 2'b00;
   endtask

   task automatic test_timeout();
      int n_to;
      n_to = 0;
      do_reset();
      p_req = 2'b11; p_we = 2'b10; p_lock = 2'b01;
      p_addr = {4'd8, 4'd2}; p_wdata = {32'h88, 32'h0};
      tick();
      checks++; if (ram_addr !== 4'd2) begin errors++; $display("FAIL to_read_issue: got %h expected 2", ram_addr); end
      tick();
      checks++; if ({p_done, rdata} !== {2'b01, 32'hA2}) begin errors++; $display("FAIL to_read_done: got %b/%h expected 01/a2", p_done, rdata); end
      p_req = 2'b10;
      for (int k = 3; k <= 20; k++) begin
         tick();
         if (lock_timeout) n_to++;
         checks++; if (lock_timeout !== (k == 17)) begin errors++; $display("FAIL to_pulse k=%0d: got %b expected %b", k, lock_timeout, (k == 17)); end
         checks++; if (ram_wren !== (k == 18)) begin errors++; $display("FAIL to_p2_wren k=%0d: got %b expected %b", k, ram_wren, (k == 18)); end
         if (k == 18) begin
            checks++; if (ram_addr !== 4'd8) begin errors++; $display("FAIL to_p2_addr: got %h expected 8", ram_addr); end
         end
         if (k == 19) begin
            checks++; if (p_done !== 2'b10) begin errors++; $display("FAIL to_p2_done: got %b expected 10", p_done); end
            p_req = 2'b00; p_lock = 2'b00; p_we = 2'b00;
         end
      end
      checks++; if (n_to !== 1) begin errors++; $display("FAIL to_pulse_count: got %0d expected 1", n_to); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      p_req = 2'b01; p_we = 2'b01; p_addr = 8'h05; p_wdata = {32'h0, 32'h55};
      tick();
      checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL rstmid_wr_issue: got %b expected 1", ram_wren); end
      resetn = 1'b0;
      tick();
      checks++; if ({ram_wren, p_done, ram_addr, ram_wdata} !== 39'h0) begin errors++; $display("FAIL rstmid_wr_abort: got %b/%b/%h/%h expected all 0", ram_wren, p_done, ram_addr, ram_wdata); end
      resetn = 1'b1; p_req = 2'b00; p_we = 2'b00;
      tick();
      checks++; if (p_done !== 2'b00) begin errors++; $display("FAIL rstmid_wr_nodone: got %b expected 00", p_done); end
      draw_req = 1'b1; draw_addr = 4'd1;
      tick();
      draw_req = 1'b0; p_req = 2'b01; p_addr = 8'h04;
      tick();
      checks++; if ({draw_rvalid, rdata, ram_addr} !== {1'b1, 32'hA1, 4'd4}) begin errors++; $display("FAIL rstmid_rd_setup: got %b/%h/%h expected 1/a1/4", draw_rvalid, rdata, ram_addr); end
      resetn = 1'b0; p_req = 2'b00;
      tick();
      checks++; if ({draw_rvalid, p_done, lock_timeout, rdata, ram_addr, ram_wren} !== 40'h0) begin errors++; $display("FAIL rstmid_rd_abort: got %b/%b/%b/%h/%h/%b expected all 0", draw_rvalid, p_done, lock_timeout, rdata, ram_addr, ram_wren); end
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if ({draw_rvalid, p_done} !== 3'b000) begin errors++; $display("FAIL rstmid_pipe_empty k=%0d: got %b/%b expected 0/00", k, draw_rvalid, p_done); end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_draw_stream();
      test_two_writes();
      test_starve();
      test_lock();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
